// File: rtl/mem_master_arbiter_pkg.sv
// ============================================================================
// Module      : mem_master_arbiter_pkg
// Description : Shared widths, FSM state encoding and port identifiers for
//               the instruction/data memory master arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

package mem_master_arbiter_pkg;

    localparam int ARB_WE_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_e;

    function automatic arb_state_e grant_state(input arb_port_e port);
        return (port == PORT_D) ? ARB_GNT_D : ARB_GNT_I;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_master_arbiter.sv
// ============================================================================
// Module      : mem_master_arbiter
// Description : Merges the instruction-fetch and data ports onto one
//               valid/ready memory bus. Grant is held for a whole transaction.
//               Define MEM_ARB_ROUND_ROBIN_EN for round-robin on contention;
//               otherwise data has fixed priority over instruction fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_master_arbiter
    import mem_master_arbiter_pkg::*;
#(
    parameter int ADDR_W = `RISCV_ADDR_WIDTH,
    parameter int DATA_W = `RISCV_WORD_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                i_valid_i,
    output logic                i_ready_o,
    input  logic [ADDR_W-1:0]   i_addr_i,
    output logic [DATA_W-1:0]   i_rdata_o,

    input  logic                d_valid_i,
    output logic                d_ready_o,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [ARB_WE_W-1:0] d_we_i,
    output logic [DATA_W-1:0]   d_rdata_o,

    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic [ADDR_W-1:0]   m_addr_o,
    output logic [DATA_W-1:0]   m_wdata_o,
    output logic [ARB_WE_W-1:0] m_we_o,
    input  logic [DATA_W-1:0]   m_rdata_i
);

    arb_state_e state_q, state_d;
    arb_port_e  contest_winner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_port_e  last_gnt_q, last_gnt_d;

    // Reset to D so the very first contested grant goes to instruction fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            last_gnt_q <= PORT_D;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    assign contest_winner = (last_gnt_q == PORT_D) ? PORT_I : PORT_D;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign contest_winner = PORT_D;
`endif

    // Bus drive is purely a function of the held grant, so an async reset
    // clears every output in the same instant the state register clears.
    always_comb begin
        state_d    = state_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_gnt_d = last_gnt_q;
`endif
        m_valid_o  = 1'b0;
        m_addr_o   = '0;
        m_wdata_o  = '0;
        m_we_o     = '0;
        i_ready_o  = 1'b0;
        i_rdata_o  = '0;
        d_ready_o  = 1'b0;
        d_rdata_o  = '0;

        case (state_q)
            ARB_IDLE: begin
                if (i_valid_i && d_valid_i) begin
                    state_d = grant_state(contest_winner);
                end else if (d_valid_i) begin
                    state_d = ARB_GNT_D;
                end else if (i_valid_i) begin
                    state_d = ARB_GNT_I;
                end
            end

            ARB_GNT_I: begin
                m_valid_o = i_valid_i;
                m_addr_o  = i_addr_i;
                i_ready_o = m_ready_i & i_valid_i;
                i_rdata_o = m_rdata_i;
                if (!i_valid_i) begin
                    state_d = ARB_IDLE;
                end else if (m_ready_i) begin
                    state_d = ARB_IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_gnt_d = PORT_I;
`endif
                end
            end

            ARB_GNT_D: begin
                m_valid_o = d_valid_i;
                m_addr_o  = d_addr_i;
                m_wdata_o = d_wdata_i;
                m_we_o    = d_we_i;
                d_ready_o = m_ready_i & d_valid_i;
                d_rdata_o = m_rdata_i;
                if (!d_valid_i) begin
                    state_d = ARB_IDLE;
                end else if (m_ready_i) begin
                    state_d = ARB_IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_gnt_d = PORT_D;
`endif
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_master_arbiter.sv
// ============================================================================
// Module      : tb_mem_master_arbiter
// Description : Directed plus randomized self-checking bench for
//               mem_master_arbiter against a transaction-level ownership model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_master_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_valid, i_ready_o;
    logic [31:0] i_addr, i_rdata_o;
    logic        d_valid, d_ready_o;
    logic [31:0] d_addr, d_wdata, d_rdata_o;
    logic [3:0]  d_we;
    logic        m_valid_o, m_ready;
    logic [31:0] m_addr_o, m_wdata_o, m_rdata;
    logic [3:0]  m_we_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: who currently owns the bus (0 none, 1 instruction, 2 data)
    // and who last completed a transaction (1 or 2).
    int owner  = 0;
    int last_g = 2;

    mem_master_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid_i (i_valid),
        .i_ready_o (i_ready_o),
        .i_addr_i  (i_addr),
        .i_rdata_o (i_rdata_o),
        .d_valid_i (d_valid),
        .d_ready_o (d_ready_o),
        .d_addr_i  (d_addr),
        .d_wdata_i (d_wdata),
        .d_we_i    (d_we),
        .d_rdata_o (d_rdata_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready),
        .m_addr_o  (m_addr_o),
        .m_wdata_o (m_wdata_o),
        .m_we_o    (m_we_o),
        .m_rdata_i (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic        e_mv, e_ir, e_dr;
        logic [31:0] e_ma, e_mw, e_id, e_dd;
        logic [3:0]  e_we;
        e_mv = 0; e_ir = 0; e_dr = 0;
        e_ma = 0; e_mw = 0; e_id = 0; e_dd = 0; e_we = 0;
        if (owner == 1) begin
            e_mv = i_valid;
            e_ma = i_addr;
            e_ir = i_valid && m_ready;
            e_id = m_rdata;
        end else if (owner == 2) begin
            e_mv = d_valid;
            e_ma = d_addr;
            e_mw = d_wdata;
            e_we = d_we;
            e_dr = d_valid && m_ready;
            e_dd = m_rdata;
        end
        chk("m_valid", {31'b0, m_valid_o}, {31'b0, e_mv});
        chk("m_addr",  m_addr_o,  e_ma);
        chk("m_wdata", m_wdata_o, e_mw);
        chk("m_we",    {28'b0, m_we_o}, {28'b0, e_we});
        chk("i_ready", {31'b0, i_ready_o}, {31'b0, e_ir});
        chk("i_rdata", i_rdata_o, e_id);
        chk("d_ready", {31'b0, d_ready_o}, {31'b0, e_dr});
        chk("d_rdata", d_rdata_o, e_dd);
    endtask

    // Called at posedge+1; moves to the falling edge where outputs are sampled.
    task automatic settle();
        #4;
    endtask

    // Applies the arbitration rules to the model, then steps to posedge+1.
    task automatic advance();
        int nxt;
        nxt = owner;
        if (owner == 0) begin
            if (i_valid && d_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                nxt = (last_g == 2) ? 1 : 2;
`else
                nxt = 2;
`endif
            end else if (d_valid) nxt = 2;
            else if (i_valid)     nxt = 1;
        end else if (owner == 1) begin
            if (!i_valid) nxt = 0;
            else if (m_ready) begin nxt = 0; last_g = 1; end
        end else begin
            if (!d_valid) nxt = 0;
            else if (m_ready) begin nxt = 0; last_g = 2; end
        end
        @(posedge clk);
        owner = nxt;
        #1;
    endtask

    task automatic cycle();
        settle();
        check_outputs();
        advance();
    endtask

    initial begin
        int pulses;
        logic done_i, done_d;

        rst_n = 0; i_valid = 0; i_addr = 0; d_valid = 0; d_addr = 0;
        d_wdata = 0; d_we = 0; m_ready = 0; m_rdata = 0;
        #1;
        check_outputs();
        @(posedge clk); #1;
        rst_n = 1;

        // Single instruction fetch with one-cycle arbitration latency
        i_valid = 1; i_addr = 32'h0000_0100;
        cycle();
        m_ready = 1; m_rdata = 32'h0000_0013;
        settle();
        check_outputs();
        chk("t1_m_valid", {31'b0, m_valid_o}, 32'd1);
        chk("t1_i_ready", {31'b0, i_ready_o}, 32'd1);
        chk("t1_i_rdata", i_rdata_o, 32'h13);
        chk("t1_d_ready", {31'b0, d_ready_o}, 32'd0);
        advance();
        i_valid = 0; m_ready = 0;
        cycle();

        // Data store with three wait states
        d_valid = 1; d_addr = 32'h0000_0804; d_wdata = 32'hDEAD_BEEF; d_we = 4'hF;
        cycle();
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            m_ready = (k == 3);
            settle();
            check_outputs();
            chk("t2_m_addr_hold", m_addr_o, 32'h0000_0804);
            pulses += int'(d_ready_o);
            advance();
        end
        chk("t2_d_ready_pulses", pulses, 32'd1);
        d_valid = 0; m_ready = 0;
        cycle();

        // Both requestors valid continuously, bus always ready
        i_valid = 1; d_valid = 1; m_ready = 1;
        i_addr = 32'h0000_0200; d_addr = 32'h0000_0900; d_we = 4'h0;
        for (int k = 0; k < 8; k++) begin
            m_rdata = 32'h1000 + k;
            cycle();
        end
        d_valid = 0;
        for (int k = 0; k < 4; k++) cycle();
        i_valid = 0; m_ready = 0;
        cycle();

        // Granted fetch abandoned before completion; pending data then served
        i_valid = 1; i_addr = 32'h0000_0300;
        cycle();
        d_valid = 1; d_addr = 32'h0000_0A00; d_we = 4'h3; d_wdata = 32'h1234_5678;
        cycle();
        i_valid = 0; m_ready = 1;
        settle();
        check_outputs();
        chk("t5_no_i_ready", {31'b0, i_ready_o}, 32'd0);
        advance();
        m_ready = 0;
        cycle();
        m_ready = 1;
        settle();
        check_outputs();
        chk("t5_d_ready", {31'b0, d_ready_o}, 32'd1);
        advance();
        d_valid = 0; m_ready = 0;
        cycle();

        // Asynchronous reset while a data transaction is waiting
        d_valid = 1; d_addr = 32'h0000_0B00; d_we = 4'hF;
        cycle();
        settle();
        check_outputs();
        m_ready = 1;
        #1;
        rst_n = 0;
        #1;
        owner = 0; last_g = 2;
        check_outputs();
        chk("t6_m_valid_rst", {31'b0, m_valid_o}, 32'd0);
        chk("t6_d_ready_rst", {31'b0, d_ready_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1; m_ready = 0;
        cycle();
        m_ready = 1;
        cycle();
        d_valid = 0; m_ready = 0;
        cycle();

        // Randomized traffic obeying the hold-until-ready protocol
        done_i = 0; done_d = 0;
        for (int n = 0; n < 400; n++) begin
            if (done_i) i_valid = 0;
            else if (i_valid && owner == 1 && $urandom_range(0, 15) == 0) i_valid = 0;
            else if (!i_valid && $urandom_range(0, 2) == 0) begin
                i_valid = 1;
                i_addr  = $urandom & 32'hFFFF_FFFC;
            end
            if (done_d) d_valid = 0;
            else if (d_valid && owner == 2 && $urandom_range(0, 15) == 0) d_valid = 0;
            else if (!d_valid && $urandom_range(0, 2) == 0) begin
                d_valid = 1;
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_we    = 4'($urandom_range(0, 15));
            end
            m_ready = 1'($urandom_range(0, 1));
            m_rdata = $urandom;
            settle();
            check_outputs();
            done_i = (owner == 1) && i_valid && m_ready;
            done_d = (owner == 2) && d_valid && m_ready;
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_master_arbiter.md
Name: mem_master_arbiter

Overview:
Two-requestor to one-bus arbiter sitting directly upstream of the memory bus address decoder. Merges the core instruction-fetch port (read-only) and data load/store port onto the single valid/ready bus that the decoder consumes. Grant is held for the full transaction; one request is outstanding at a time.

Parameters:
ADDR_W, `RISCV_ADDR_WIDTH, address width of all ports
DATA_W, `RISCV_WORD_WIDTH, data width of all ports

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous reset, active low
i_valid_i  in  1  instruction fetch request
i_ready_o  out  1  instruction transaction complete this cycle
i_addr_i  in  ADDR_W  fetch address
i_rdata_o  out  DATA_W  fetch data, valid when i_ready_o=1
d_valid_i  in  1  data request
d_ready_o  out  1  data transaction complete this cycle
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  store data
d_we_i  in  4  byte write enables; 0 = read
d_rdata_o  out  DATA_W  load data, valid when d_ready_o=1
m_valid_o  out  1  request to decoder
m_ready_i  in  1  decoder/slave completion
m_addr_o  out  ADDR_W  forwarded address
m_wdata_o  out  DATA_W  forwarded store data
m_we_o  out  4  forwarded byte enables
m_rdata_i  in  DATA_W  returned read data

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- State register: IDLE, GNT_I, GNT_D. Reset -> IDLE; last_gnt register reset to D (so first contested grant goes to I under round-robin).
- Reset values / IDLE outputs: m_valid_o=0, m_addr_o=0, m_wdata_o=0, m_we_o=0, i_ready_o=0, d_ready_o=0, i_rdata_o=0, d_rdata_o=0.
- IDLE: if any valid, pick winner, register grant; next cycle enter GNT_x. No bus drive in IDLE (1-cycle arbitration latency).
- Fixed priority (default): d_valid_i beats i_valid_i.
- GNT_I: m_valid_o=i_valid_i, m_addr_o=i_addr_i, m_we_o=0, m_wdata_o=0; i_ready_o=m_ready_i; i_rdata_o=m_rdata_i; d side ready=0, rdata=0.
- GNT_D: m_valid_o=d_valid_i, address/wdata/we from d port; d_ready_o=m_ready_i; d_rdata_o=m_rdata_i; i side ready=0, rdata=0.
- Completion: m_valid_o & m_ready_i in GNT_x -> update last_gnt=x, go IDLE next cycle. Minimum transaction = 2 cycles (arbitrate + access); back-to-back requests see one IDLE bubble.
- Ready/rdata paths from m_ready_i/m_rdata_i are combinational (same-cycle completion).
- Requestors hold valid and payload stable until ready. If the granted requestor drops valid before ready: return to IDLE next cycle, no ready pulse, last_gnt unchanged.
- Loser stays pending; its valid is re-evaluated in the following IDLE.
- m_ready_i asserted while in IDLE or with m_valid_o=0: ignored.
- Reset mid-transaction: immediate return to IDLE, all outputs to reset values; in-flight transaction dropped.

Optional Feature:
MEM_ARB_ROUND_ROBIN_EN: defined -> when both valid in IDLE, grant the port not equal to last_gnt; single requester granted directly. Undefined -> fixed data-over-instruction priority; last_gnt register not built.

Decomposition:
- Shared package/defines (riscv_defines.v): state encodings ARB_IDLE=2'd0, ARB_GNT_I=2'd1, ARB_GNT_D=2'd2; width macros already present.
- No sub-module; single module with state register and combinational output mux.

Test Plan:
- Reset then only i_valid_i=1, i_addr_i=0x0000_0100, m_ready_i=1 after 1 cycle, m_rdata_i=0x0000_0013 -> m_valid_o high in cycle 2, m_we_o=0, i_ready_o=1 same cycle with i_rdata_o=0x13, d_ready_o=0.
- d store d_addr_i=0x0000_0804, d_wdata_i=0xDEADBEEF, d_we_i=4'hF, m_ready_i delayed 3 cycles -> m_* held stable 3 cycles, d_ready_o single pulse on 4th GNT cycle.
- Both valid continuously, fixed priority -> D granted every arbitration; I never granted until d_valid_i drops.
- Same with MEM_ARB_ROUND_ROBIN_EN, m_ready_i=1 -> grants alternate I,D,I,D; each 2 cycles.
- Granted I drops i_valid_i before m_ready_i -> no i_ready_o, IDLE next cycle, pending D granted after.
- rst_n asserted in GNT_D mid-wait -> m_valid_o, d_ready_o, all outputs 0 immediately; after release, state IDLE.
